// File: rtl/mps_core_mc_if.sv
// Memory-side bundle of the multi-cycle MPS core: instruction fetch and
// data access request/acknowledge handshakes.
interface mps_core_mc_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int DMEM_ADDR_WIDTH = 8,
    parameter int IMEM_ADDR_WIDTH = 8
);
    logic                       imem_req;
    logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
    logic                       imem_ack;
    logic [15:0]                imem_value;
    logic                       dmem_req;
    logic                       dmem_wenable;
    logic [DMEM_ADDR_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0]      dmem_wvalue;
    logic                       dmem_ack;
    logic [DATA_WIDTH-1:0]      dmem_rvalue;

    // Core side: drives requests, receives acknowledges and data.
    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_value,
        output dmem_req, dmem_wenable, dmem_addr, dmem_wvalue,
        input  dmem_ack, dmem_rvalue
    );

    // Memory side: receives requests, returns acknowledges and data.
    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_value,
        input  dmem_req, dmem_wenable, dmem_addr, dmem_wvalue,
        output dmem_ack, dmem_rvalue
    );
endinterface

// File: rtl/mps_core_mc.sv
// Multi-cycle MPS core: FETCH -> EXEC -> (MEM) -> FETCH, with handshaked
// instruction/data memories, JNZ and a sticky FAULT state on illegal opcodes.
// Opcode encodings follow the MPS set (SET=0 .. STORE=11); JNZ takes 4'hC,
// the first unused encoding. 4'hD..4'hF are illegal.
module mps_core_mc #(
    parameter int DATA_WIDTH      = 8,
    parameter int DMEM_ADDR_WIDTH = 8,
    parameter int IMEM_ADDR_WIDTH = 8,
    parameter int REGS_COUNT      = 16
) (
    input  logic          clock,
    input  logic          nreset,
    mps_core_mc_if.master bus,
    output logic          retire,
    output logic          fault
);
    localparam logic [3:0] OP_SET   = 4'h0;
    localparam logic [3:0] OP_DUP   = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_LSH   = 4'h4;
    localparam logic [3:0] OP_RSH   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_AND   = 4'h7;
    localparam logic [3:0] OP_XOR   = 4'h8;
    localparam logic [3:0] OP_NOT   = 4'h9;
    localparam logic [3:0] OP_LOAD  = 4'hA;
    localparam logic [3:0] OP_STORE = 4'hB;
    localparam logic [3:0] OP_JNZ   = 4'hC;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t                     state_r;
    logic [15:0]                instr_r;
    logic [IMEM_ADDR_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0]      regs_r [0:15];
    logic                       imem_req_r;
    logic                       dmem_req_r;
    logic                       dmem_wenable_r;
    logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_r;
    logic [DATA_WIDTH-1:0]      dmem_wvalue_r;
    logic                       retire_r;
    logic                       fault_r;

    logic [3:0]                 opcode_s;
    logic [3:0]                 rd_s;
    logic [3:0]                 ra_s;
    logic [3:0]                 rb_s;
    logic [7:0]                 imm_s;
    logic [DATA_WIDTH-1:0]      op_a_s;
    logic [DATA_WIDTH-1:0]      op_b_s;
    logic [DATA_WIDTH-1:0]      alu_s;
    logic                       legal_s;
    logic                       shift_big_s;
    logic [IMEM_ADDR_WIDTH-1:0] pc_inc_s;

    // r0 and indices beyond the implemented register count read 0 and drop writes.
    function automatic logic reg_valid(input logic [3:0] idx);
        return (idx != 4'd0) && (int'(idx) < REGS_COUNT);
    endfunction

    assign opcode_s    = instr_r[3:0];
    assign rd_s        = instr_r[7:4];
    assign ra_s        = instr_r[11:8];
    assign rb_s        = instr_r[15:12];
    assign imm_s       = instr_r[15:8];
    assign op_a_s      = reg_valid(ra_s) ? regs_r[ra_s] : '0;
    assign op_b_s      = reg_valid(rb_s) ? regs_r[rb_s] : '0;
    assign shift_big_s = (op_b_s >= DATA_WIDTH'(DATA_WIDTH));
    assign pc_inc_s    = pc_r + IMEM_ADDR_WIDTH'(1);

    // ALU result and legality of the latched instruction.
    always_comb begin
        alu_s   = '0;
        legal_s = 1'b1;
        case (opcode_s)
            OP_SET:   alu_s = DATA_WIDTH'(imm_s);
            OP_DUP:   alu_s = op_a_s;
            OP_ADD:   alu_s = op_a_s + op_b_s;
            OP_SUB:   alu_s = op_a_s - op_b_s;
            OP_LSH:   alu_s = shift_big_s ? '0 : (op_a_s << op_b_s);
            OP_RSH:   alu_s = shift_big_s ? '0 : (op_a_s >> op_b_s);
            OP_OR:    alu_s = op_a_s | op_b_s;
            OP_AND:   alu_s = op_a_s & op_b_s;
            OP_XOR:   alu_s = op_a_s ^ op_b_s;
            OP_NOT:   alu_s = ~op_a_s;
            OP_LOAD:  alu_s = '0;
            OP_STORE: alu_s = '0;
            OP_JNZ:   alu_s = '0;
            default:  legal_s = 1'b0;
        endcase
    end

    // Control FSM, register file, PC and all registered outputs.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_r        <= ST_FETCH;
            instr_r        <= 16'h0000;
            pc_r           <= '0;
            imem_req_r     <= 1'b0;
            dmem_req_r     <= 1'b0;
            dmem_wenable_r <= 1'b0;
            dmem_addr_r    <= '0;
            dmem_wvalue_r  <= '0;
            retire_r       <= 1'b0;
            fault_r        <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            retire_r <= 1'b0;
            case (state_r)
                ST_FETCH: begin
                    // An ack only counts while our request is actually visible,
                    // so a stale ack right after reset is ignored.
                    if (imem_req_r && bus.imem_ack) begin
                        instr_r    <= bus.imem_value;
                        imem_req_r <= 1'b0;
                        state_r    <= ST_EXEC;
                    end else begin
                        imem_req_r <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    case (opcode_s)
                        OP_LOAD, OP_STORE: begin
                            dmem_req_r     <= 1'b1;
                            dmem_wenable_r <= (opcode_s == OP_STORE);
                            dmem_addr_r    <= DMEM_ADDR_WIDTH'(op_a_s);
                            dmem_wvalue_r  <= op_b_s;
                            state_r        <= ST_MEM;
                        end
                        OP_JNZ: begin
                            pc_r       <= (op_a_s != '0) ? IMEM_ADDR_WIDTH'(op_b_s) : pc_inc_s;
                            retire_r   <= 1'b1;
                            imem_req_r <= 1'b1;
                            state_r    <= ST_FETCH;
                        end
                        default: begin
                            if (legal_s) begin
                                if (reg_valid(rd_s)) begin
                                    regs_r[rd_s] <= alu_s;
                                end
                                pc_r       <= pc_inc_s;
                                retire_r   <= 1'b1;
                                imem_req_r <= 1'b1;
                                state_r    <= ST_FETCH;
                            end else begin
                                fault_r <= 1'b1;
                                state_r <= ST_FAULT;
                            end
                        end
                    endcase
                end
                ST_MEM: begin
                    if (bus.dmem_ack) begin
                        if (!dmem_wenable_r && reg_valid(rd_s)) begin
                            regs_r[rd_s] <= bus.dmem_rvalue;
                        end
                        dmem_req_r     <= 1'b0;
                        dmem_wenable_r <= 1'b0;
                        dmem_addr_r    <= '0;
                        dmem_wvalue_r  <= '0;
                        pc_r           <= pc_inc_s;
                        retire_r       <= 1'b1;
                        imem_req_r     <= 1'b1;
                        state_r        <= ST_FETCH;
                    end else begin
                        state_r <= ST_MEM;
                    end
                end
                ST_FAULT: begin
                    state_r <= ST_FAULT;
                end
                default: begin
                    state_r <= ST_FAULT;
                    fault_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.imem_req     = imem_req_r;
    assign bus.imem_addr    = pc_r;
    assign bus.dmem_req     = dmem_req_r;
    assign bus.dmem_wenable = dmem_wenable_r;
    assign bus.dmem_addr    = dmem_addr_r;
    assign bus.dmem_wvalue  = dmem_wvalue_r;
    assign retire           = retire_r;
    assign fault            = fault_r;
endmodule

// File: tb/tb_mps_core_mc.sv
// Bench for mps_core_mc: instruction-level reference model with a latency
// schedule, randomized memory wait states and programs, plus directed
// programs with hand-computed results.
module tb_mps_core_mc;
    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int IW  = 8;
    localparam int MOD = 1 << DW;

    localparam int OP_SET = 0, OP_DUP = 1, OP_ADD = 2, OP_SUB = 3, OP_LSH = 4;
    localparam int OP_RSH = 5, OP_OR = 6, OP_AND = 7, OP_XOR = 8, OP_NOT = 9;
    localparam int OP_LOAD = 10, OP_STORE = 11, OP_JNZ = 12;

    logic clock  = 1'b0;
    logic nreset = 1'b0;
    logic retire;
    logic fault;

    mps_core_mc_if #(.DATA_WIDTH(DW), .DMEM_ADDR_WIDTH(AW), .IMEM_ADDR_WIDTH(IW)) bus ();

    mps_core_mc #(
        .DATA_WIDTH(DW), .DMEM_ADDR_WIDTH(AW), .IMEM_ADDR_WIDTH(IW), .REGS_COUNT(16)
    ) dut (
        .clock (clock),
        .nreset(nreset),
        .bus   (bus),
        .retire(retire),
        .fault (fault)
    );

    always #5 clock = ~clock;

    logic [15:0] prog [0:255];
    int          dmem [0:255];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model: architectural state plus the cycle schedule of outputs
    int m_regs [0:15];
    int m_pc, pc_after, retire_at, fetch_from, mem_from, fault_at;
    int mem_addr, mem_wval, mem_rd;
    bit fetch_open, mem_pending, mem_wen, fault_set, model_valid = 1'b0;

    // stimulus controls
    bit rst_req = 1'b0;
    bit late_ack = 1'b0;
    bit dmem_never = 1'b0;
    int imem_wait_max = 0;
    int dmem_wait_max = 0;
    int dmem_fixed = -1;
    int dmem_age = 0;

    int fetch_log [$];
    int fetch_cyc_log [$];
    int retire_log [$];
    int ack_age_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int d, input int a, input int b);
        return {4'(b), 4'(a), 4'(d), 4'(op)};
    endfunction

    function automatic logic [15:0] set_i(input int d, input int imm);
        return {8'(imm), 4'(d), 4'(OP_SET)};
    endfunction

    function automatic int model_alu(input int op, input int av, input int bv, input int imm);
        case (op)
            OP_SET:  return imm;
            OP_DUP:  return av;
            OP_ADD:  return (av + bv) % MOD;
            OP_SUB:  return (av - bv + MOD) % MOD;
            OP_LSH:  return (bv >= DW) ? 0 : (av * (1 << bv)) % MOD;
            OP_RSH:  return (bv >= DW) ? 0 : av / (1 << bv);
            OP_OR:   return av | bv;
            OP_AND:  return av & bv;
            OP_XOR:  return av ^ bv;
            OP_NOT:  return MOD - 1 - av;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 0;
        m_pc = 0; pc_after = 0; retire_at = -1;
        fetch_open = 1'b1; fetch_from = cyc + 2;
        mem_pending = 1'b0; fault_set = 1'b0; fault_at = 0;
        model_valid = 1'b1;
    endtask

    // instruction fetched this cycle: apply its architectural effect and schedule outputs
    task automatic model_exec(input logic [15:0] instr);
        int op, d, a, b, imm, av, bv;
        op = int'(instr[3:0]); d = int'(instr[7:4]);
        a = int'(instr[11:8]); b = int'(instr[15:12]); imm = int'(instr[15:8]);
        av = m_regs[a]; bv = m_regs[b];
        fetch_open = 1'b0;
        if (op > OP_JNZ) begin
            fault_set = 1'b1; fault_at = cyc + 2;
        end else if (op == OP_LOAD || op == OP_STORE) begin
            mem_pending = 1'b1; mem_from = cyc + 2;
            mem_addr = av; mem_wen = (op == OP_STORE); mem_wval = bv; mem_rd = d;
        end else begin
            if (op == OP_JNZ) pc_after = (av != 0) ? bv % (1 << IW) : (m_pc + 1) % (1 << IW);
            else begin
                if (d != 0) m_regs[d] = model_alu(op, av, bv, imm);
                pc_after = (m_pc + 1) % (1 << IW);
            end
            retire_at = cyc + 2; fetch_open = 1'b1; fetch_from = cyc + 2;
        end
    endtask

    // one clock: compare outputs against the model, drive memory responses, advance model
    task automatic step();
        bit e_ireq, e_dreq, ia, da;
        @(negedge clock);
        cyc++;
        e_ireq = 1'b0; e_dreq = 1'b0;
        if (model_valid) begin
            if (retire_at == cyc) m_pc = pc_after;
            e_ireq = fetch_open && (cyc >= fetch_from);
            e_dreq = mem_pending && (cyc >= mem_from);
            check("imem_req", 32'(bus.imem_req), 32'(e_ireq));
            check("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
            check("retire", 32'(retire), 32'(retire_at == cyc));
            check("fault", 32'(fault), 32'(fault_set && cyc >= fault_at));
            check("dmem_req", 32'(bus.dmem_req), 32'(e_dreq));
            check("dmem_wenable", 32'(bus.dmem_wenable), e_dreq ? 32'(mem_wen) : 32'd0);
            check("dmem_addr", 32'(bus.dmem_addr), e_dreq ? 32'(mem_addr % (1 << AW)) : 32'd0);
            check("dmem_wvalue", 32'(bus.dmem_wvalue), e_dreq ? 32'(mem_wval) : 32'd0);
        end
        if (retire === 1'b1) retire_log.push_back(cyc);

        nreset = !rst_req;
        ia = late_ack || (bus.imem_req === 1'b1 && $urandom_range(0, imem_wait_max) == 0);
        bus.imem_ack = ia;
        if (late_ack) bus.imem_value = 16'hFFFF;
        else if (ia) bus.imem_value = prog[bus.imem_addr];
        else bus.imem_value = 16'($urandom);

        if (bus.dmem_req === 1'b1) dmem_age++; else dmem_age = 0;
        if (dmem_never) da = 1'b0;
        else if (dmem_fixed >= 0) da = (bus.dmem_req === 1'b1) && (dmem_age == dmem_fixed + 1);
        else da = (bus.dmem_req === 1'b1) && ($urandom_range(0, dmem_wait_max) == 0);
        da = da || late_ack;
        bus.dmem_ack = da;
        bus.dmem_rvalue = da ? DW'(dmem[bus.dmem_addr]) : DW'($urandom);
        if (da && bus.dmem_req === 1'b1) begin
            ack_age_log.push_back(dmem_age);
            if (bus.dmem_wenable === 1'b1) dmem[bus.dmem_addr] = int'(bus.dmem_wvalue);
        end

        if (!nreset) model_reset();
        else if (model_valid) begin
            if (e_ireq && ia) begin
                fetch_log.push_back(m_pc);
                fetch_cyc_log.push_back(cyc);
                model_exec(prog[m_pc]);
            end
            if (e_dreq && da) begin
                mem_pending = 1'b0;
                if (!mem_wen && mem_rd != 0) m_regs[mem_rd] = int'(bus.dmem_rvalue);
                pc_after = (m_pc + 1) % (1 << IW);
                retire_at = cyc + 1; fetch_open = 1'b1; fetch_from = cyc + 1;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
    endtask

    task automatic clear_logs();
        fetch_log.delete(); fetch_cyc_log.delete(); retire_log.delete(); ack_age_log.delete();
    endtask

    task automatic load_prog(input logic [15:0] words [], input int n);
        for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
        for (int i = 0; i < n; i++) prog[i] = words[i];
        for (int i = 0; i < 256; i++) dmem[i] = 8'hEE;
    endtask

    task automatic zero_wait();
        imem_wait_max = 0; dmem_wait_max = 0; dmem_fixed = -1; dmem_never = 1'b0;
    endtask

    initial begin
        logic [15:0] p [];
        bus.imem_ack = 1'b0; bus.imem_value = 16'h0000;
        bus.dmem_ack = 1'b0; bus.dmem_rvalue = '0;

        // 1: SET/SET/ADD, zero wait, then expose r3 via STORE
        p = new[5];
        p[0] = set_i(1, 5); p[1] = set_i(2, 7); p[2] = enc(OP_ADD, 3, 1, 2);
        p[3] = set_i(4, 8'h20); p[4] = enc(OP_STORE, 0, 4, 3);
        load_prog(p, 5); zero_wait();
        do_reset(); clear_logs();
        run(20);
        check("t1_retire_count", 32'(retire_log.size() >= 3), 32'd1);
        if (retire_log.size() >= 3 && fetch_cyc_log.size() >= 1)
            check("t1_three_instr_cycles", 32'(retire_log[2] - fetch_cyc_log[0]), 32'd6);
        check("t1_r3_sum", 32'(dmem[8'h20]), 32'd12);

        // 2: STORE/LOAD with a 3-cycle dmem delay
        p = new[6];
        p[0] = set_i(1, 8'h10); p[1] = set_i(2, 8'hAB); p[2] = enc(OP_STORE, 0, 1, 2);
        p[3] = enc(OP_LOAD, 4, 1, 0); p[4] = set_i(5, 8'h30); p[5] = enc(OP_STORE, 0, 5, 4);
        load_prog(p, 6); zero_wait(); dmem_fixed = 3;
        do_reset(); clear_logs();
        run(40);
        check("t2_ack_count", 32'(ack_age_log.size() >= 1), 32'd1);
        if (ack_age_log.size() >= 1) check("t2_req_held", 32'(ack_age_log[0]), 32'd4);
        check("t2_store_data", 32'(dmem[8'h10]), 32'hAB);
        check("t2_loaded_r4", 32'(dmem[8'h30]), 32'hAB);

        // 3a: JNZ taken back to 0
        p = new[3];
        p[0] = set_i(1, 3); p[1] = set_i(2, 0); p[2] = enc(OP_JNZ, 0, 1, 2);
        load_prog(p, 3); zero_wait();
        do_reset(); clear_logs();
        run(20);
        check("t3a_fetch_count", 32'(fetch_log.size() >= 4), 32'd1);
        if (fetch_log.size() >= 4) check("t3a_jump_target", 32'(fetch_log[3]), 32'd0);

        // 3b: JNZ not taken falls through
        p = new[6];
        p[0] = set_i(1, 0); p[1] = set_i(2, 8'h40); p[2] = enc(OP_JNZ, 0, 1, 2);
        p[3] = set_i(5, 8'h33); p[4] = set_i(6, 8'h50); p[5] = enc(OP_STORE, 0, 6, 5);
        load_prog(p, 6); zero_wait();
        do_reset(); clear_logs();
        run(30);
        check("t3b_fetch_count", 32'(fetch_log.size() >= 4), 32'd1);
        if (fetch_log.size() >= 4) check("t3b_fallthrough", 32'(fetch_log[3]), 32'd3);
        check("t3b_store", 32'(dmem[8'h50]), 32'h33);

        // 4: wrap, oversize shift, r0 hardwired
        p = new[11];
        p[0] = set_i(1, 8'hFF); p[1] = set_i(2, 1); p[2] = enc(OP_ADD, 3, 1, 2);
        p[3] = set_i(2, 8); p[4] = enc(OP_LSH, 4, 1, 2); p[5] = set_i(0, 9);
        p[6] = set_i(5, 8'h60); p[7] = enc(OP_STORE, 0, 5, 3);
        p[8] = set_i(5, 8'h61); p[9] = enc(OP_STORE, 0, 5, 4);
        p[10] = enc(OP_STORE, 0, 0, 0);
        load_prog(p, 11); zero_wait();
        do_reset(); clear_logs();
        run(50);
        check("t4_add_wrap", 32'(dmem[8'h60]), 32'd0);
        check("t4_lsh_big", 32'(dmem[8'h61]), 32'd0);
        check("t4_r0_zero", 32'(dmem[8'h00]), 32'd0);

        // 5: illegal opcode -> sticky fault, cleared only by reset
        p = new[2];
        p[0] = set_i(1, 1); p[1] = 16'h000F;
        load_prog(p, 2); zero_wait();
        do_reset(); clear_logs();
        run(12);
        check("t5_fault", 32'(fault), 32'd1);
        check("t5_no_fetch", 32'(bus.imem_req), 32'd0);
        check("t5_retires", 32'(retire_log.size()), 32'd1);
        do_reset();
        step();
        check("t5_fault_cleared", 32'(fault), 32'd0);
        check("t5_pc_zero", 32'(bus.imem_addr), 32'd0);

        // 6: reset during an unacked load, then a late ack on both memories
        p = new[2];
        p[0] = set_i(1, 8'h10); p[1] = enc(OP_LOAD, 2, 1, 0);
        load_prog(p, 2); zero_wait(); dmem_never = 1'b1;
        do_reset(); clear_logs();
        run(8);
        check("t6_stalled_in_mem", 32'(bus.dmem_req), 32'd1);
        do_reset();
        late_ack = 1'b1;
        step();
        late_ack = 1'b0;
        check("t6_req_dropped", 32'(bus.dmem_req), 32'd0);
        p[0] = set_i(5, 8'h70); p[1] = enc(OP_STORE, 0, 5, 2);
        load_prog(p, 2); zero_wait(); clear_logs();
        run(20);
        check("t6_refetch_at_0", 32'(fetch_log.size() >= 1 ? fetch_log[0] : -1), 32'd0);
        check("t6_no_load_write", 32'(dmem[8'h70]), 32'd0);
        check("t6_no_fault", 32'(fault), 32'd0);

        // 7: random programs with random wait states and mid-run resets
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 256; i++) begin
                int op;
                op = $urandom_range(0, OP_JNZ);
                if (op == OP_SET) prog[i] = set_i($urandom_range(0, 15), $urandom_range(0, 255));
                else prog[i] = enc(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
                dmem[i] = $urandom_range(0, 255);
            end
            dmem_fixed = -1; dmem_never = 1'b0;
            imem_wait_max = r % 3; dmem_wait_max = (r + 1) % 3;
            do_reset(); run(200);
            do_reset(); run(200);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mps_core_mc.md
# mps_core_mc

Multi-cycle, parametrised successor to the MPS single-cycle core. It keeps the 16-bit MPS instruction format and ALU operation set and adds three things: request/acknowledge handshakes on both memories (so slow or shared memories stall the core), a conditional jump, and a sticky fault state for illegal opcodes. It sits between the instruction ROM and the data RAM/bus arbiter, and exposes retire/fault status for the system controller and the testbench.

## Interface
Parameters:
- `DATA_WIDTH`, 8: register, ALU and data-memory word width (≥ 8).
- `DMEM_ADDR_WIDTH`, 8: data address width. Addresses are the low bits of register A.
- `IMEM_ADDR_WIDTH`, 8: program counter width.
- `REGS_COUNT`, 16: number of registers (≤ 16). r0 reads 0 and ignores writes.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `nreset`  in  1  reset, synchronous, active-low.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  IMEM_ADDR_WIDTH  fetch address (= PC).
- `imem_ack`  in  1  `imem_value` is valid this cycle.
- `imem_value`  in  16  instruction word.
- `dmem_req`  out  1  data access request.
- `dmem_wenable`  out  1  1 = store, 0 = load.
- `dmem_addr`  out  DMEM_ADDR_WIDTH  data address.
- `dmem_wvalue`  out  DATA_WIDTH  store data.
- `dmem_ack`  in  1  access complete; `dmem_rvalue` is valid for loads.
- `dmem_rvalue`  in  DATA_WIDTH  load data.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `fault`  out  1  sticky; set by an illegal opcode.

## Operation
- Decode fields: opcode [3:0], d [7:4], a [11:8], b [15:12], imm [15:8].
- Register indices ≥ REGS_COUNT read 0 and are not written.
- Opcode set: the existing `OPCODE_*` defines (SET, DUP, ADD, SUB, LSH, RSH, OR, AND, XOR, NOT, LOAD, STORE) plus the new `OPCODE_JNZ`, added to config.inc.v at a currently unused encoding.
- JNZ: if reg[a] ≠ 0, PC ← reg[b] truncated/zero-extended to IMEM_ADDR_WIDTH; otherwise PC ← PC+1. No register write.
- Any other encoding is illegal.
- Arithmetic:
  - ADD/SUB wrap modulo 2^DATA_WIDTH.
  - LSH/RSH are logical. A shift amount ≥ DATA_WIDTH yields 0.
  - SET zero-extends imm.
- FSM states:
  - FETCH: `imem_req`=1, `imem_addr`=PC. On `imem_ack`, latch the instruction → EXEC. With no ack, stay.
  - EXEC:
    - ALU/SET/DUP: write rd, PC+1, `retire`=1 → FETCH.
    - JNZ: update PC, `retire`=1 → FETCH.
    - LOAD/STORE: latch address = reg[a] and wdata = reg[b] → MEM.
    - Illegal: → FAULT. PC is not advanced and there is no retire.
  - MEM: `dmem_req`=1; addr, wenable and wvalue are held stable. On `dmem_ack`: a load writes rd ← `dmem_rvalue`; PC+1; `retire`=1 → FETCH. With no ack, stay (unbounded wait).
  - FAULT: `fault`=1, all requests 0. Left only by reset.
- `dmem_*` outputs are 0 whenever `dmem_req`=0. `imem_addr` always shows PC.
- PC wraps from 2^IMEM_ADDR_WIDTH−1 to 0.

## Timing
- On reset (`nreset`=0 at a rising edge): state=FETCH, PC=0, all registers 0, `fault`=0. All outputs 0 in the following cycle, except that `imem_req` rises in the first cycle after `nreset` is released.
- Reset asserted mid-operation (FETCH or MEM with a request outstanding): requests drop in the next cycle. A late ack is ignored and any pending load write is discarded.
- Latency, with zero-wait acks (ack in the same cycle as req):
  - ALU/JNZ: 2 cycles per instruction.
  - LOAD/STORE: 3 cycles.
  - Each wait cycle adds 1.
- A register written in EXEC/MEM is visible to the next instruction's EXEC (no hazard, no bypass needed).
- `retire` is high for exactly one cycle per completed instruction and is never high in FAULT.
- A store is committed by the memory on the `dmem_ack` cycle. The core never asserts `dmem_req` for more than one access per instruction.

## Test plan
- Reset then program SET r1,5; SET r2,7; ADD r3,r1,r2 with zero-wait imem → r3=12, three retire pulses, 6 cycles total.
- SET r1,0x10; SET r2,0xAB; STORE [r1],r2; LOAD r4,[r1] with dmem_ack delayed 3 cycles → dmem_req held 4 cycles, addr=0x10, wvalue=0xAB, r4=0xAB.
- SET r1,3; SET r2,0; JNZ r1,r2 → next imem_addr=0. SET r1,0; JNZ r1,r2 → PC+1.
- DATA_WIDTH=8: SET r1,0xFF; SET r2,1; ADD r3,r1,r2 → r3=0. SET r2,8; LSH r3,r1,r2 → r3=0. SET r0,9 → r0 reads 0.
- Illegal opcode word → fault=1 the next cycle, imem_req=0, no retire. Assert nreset → fault=0, PC=0.
- Assert nreset during MEM with no ack, then ack one cycle later → dmem_req=0, no register write, fetch restarts at address 0.
